instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Fetch stage feeding the combinational program memory ROM. Holds the PC, drives
//  the ROM address, selects the next PC (sequential/branch/jump/jr), and captures
//  the returned word into the IF/ID pipeline register. Supports stall, flush and a
//  sticky misalignment fault that halts fetch.
// PARAMETERS
//  DATA_WIDTH  32            instruction/address width
//  RESET_PC    32'h00000000  PC value loaded on reset (word aligned)
// PORTS
//  clk              in   1   single clock; all state updates on rising edge
//  reset            in   1   synchronous, active-low
//  stall            in   1   hazard hold: keep PC and IF/ID
//  flush            in   1   squash IF/ID (load NOP, valid=0)
//  pc_src           in   2   next-PC select: 00 PC+4, 01 branch, 10 jump, 11 jr
//  branch_target    in   32  absolute branch target from ID
//  jump_index       in   26  J-type index field from ID
//  jr_address       in   32  register value for jr
//  instruction_in   in   32  word returned by program memory for pc_out
//  pc_out           out  32  current PC; drives program memory Address
//  if_id_instr      out  32  IF/ID registered instruction
//  if_id_pc_plus4   out  32  IF/ID registered PC+4
//  if_id_valid      out  1   IF/ID holds a real instruction
//  fault            out  1   sticky: misaligned next PC detected
//  fetch_count      out  32  instructions accepted into IF/ID
// BEHAVIOUR
//  - Reset (reset==0 at edge): PC=RESET_PC, if_id_instr=0 (NOP), if_id_pc_plus4=0,
//    if_id_valid=0, fault=0, fetch_count=0, state=RUN. Overrides all other inputs.
//  - pc_out = PC register directly (no comb logic); ROM returns word same cycle.
//  - next_pc: 00 PC+4; 01 branch_target; 10 {if_id_pc_plus4[31:28],jump_index,2'b00};
//    11 jr_address. Adder wraps mod 2^32 (0xFFFFFFFC+4 -> 0x0).
//  - FSM: RUN, HALT.
//    RUN, priority per edge:
//      1) next_pc[1:0]!=0 and (flush or !stall): -> HALT, fault=1, PC held,
//         IF/ID loaded NOP, valid=0.
//      2) flush: PC<=next_pc, IF/ID<=NOP (instr 0, pc_plus4 0), valid=0.
//         flush overrides stall.
//      3) stall: PC, IF/ID, valid, fetch_count all held.
//      4) else: PC<=next_pc, if_id_instr<=instruction_in, if_id_pc_plus4<=PC+4,
//         valid=1, fetch_count+=1 (wraps 0xFFFFFFFF->0).
//    HALT: all state held, fault=1, valid=0; exits only by reset.
//  - Redirect (pc_src!=00) with stall=1, flush=0: treated as stall; PC held.
//    Redirects must be accompanied by flush to squash the wrong-path fetch.
//  - Latency: instruction at PC appears on if_id_instr 1 edge after PC presented.
//  - fetch_count never increments on flush, stall, HALT or reset cycles.
//  - Reset mid-stall/flush/HALT: reset wins; next cycle fetches RESET_PC.
// TESTING
//  1) reset low 2 cycles, release, ROM[0..3]=A,B,C,D -> pc_out 0,4,8,C;
//     if_id_instr A,B,C one cycle late; valid=1 from 1st edge; fetch_count=3 at PC=C.
//  2) stall high 3 cycles at PC=8 -> pc_out stays 8, if_id_instr stays B,
//     fetch_count frozen; release -> C loaded next edge.
//  3) pc_src=01, branch_target=0x40, flush=1 -> PC=0x40, valid=0, instr=0;
//     next edge loads ROM[0x40>>2], valid=1.
//  4) if_id_pc_plus4=0x10000008, jump_index=0x0000010, pc_src=10, flush=1 ->
//     PC=0x10000040; then pc_src=11, jr_address=0x24, flush=1 -> PC=0x24.
//  5) pc_src=11, jr_address=0x26, flush=1 -> fault=1, PC held, valid=0 thereafter;
//     stall/flush ignored; reset -> fault=0, PC=RESET_PC.
//  6) stall=1,flush=1 same edge -> flush wins (PC advances, NOP); PC=0xFFFFFFFC
//     sequential -> wraps to 0x0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch stage: PC, next-PC select, IF/ID register, misalignment halt
module instruction_fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [1:0]            pc_src,
    input  logic [DATA_WIDTH-1:0] branch_target,
    input  logic [25:0]           jump_index,
    input  logic [DATA_WIDTH-1:0] jr_address,
    input  logic [DATA_WIDTH-1:0] instruction_in,
    output logic [DATA_WIDTH-1:0] pc_out,
    output logic [DATA_WIDTH-1:0] if_id_instr,
    output logic [DATA_WIDTH-1:0] if_id_pc_plus4,
    output logic                  if_id_valid,
    output logic                  fault,
    output logic [DATA_WIDTH-1:0] fetch_count
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] if_id_instr_q, if_id_instr_d;
    logic [DATA_WIDTH-1:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
    logic                  if_id_valid_q, if_id_valid_d;
    logic                  fault_q, fault_d;
    logic [DATA_WIDTH-1:0] fetch_count_q, fetch_count_d;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] next_pc;

    assign pc_plus4 = pc_q + DATA_WIDTH'(4);

    // Jump region comes from the instruction being decoded, i.e. the IF/ID copy of PC+4.
    always_comb begin
        next_pc = pc_plus4;
        case (pc_src)
            2'b00:   next_pc = pc_plus4;
            2'b01:   next_pc = branch_target;
            2'b10:   next_pc = {if_id_pc_plus4_q[DATA_WIDTH-1 -: 4], jump_index, 2'b00};
            default: next_pc = jr_address;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        if_id_instr_d    = if_id_instr_q;
        if_id_pc_plus4_d = if_id_pc_plus4_q;
        if_id_valid_d    = if_id_valid_q;
        fault_d          = fault_q;
        fetch_count_d    = fetch_count_q;
        case (state_q)
            RUN: begin
                // A misaligned target only matters when the PC would actually move.
                if ((next_pc[1:0] != 2'b00) && (flush || !stall)) begin
                    state_d          = HALT;
                    fault_d          = 1'b1;
                    if_id_instr_d    = '0;
                    if_id_pc_plus4_d = '0;
                    if_id_valid_d    = 1'b0;
                end else if (flush) begin
                    pc_d             = next_pc;
                    if_id_instr_d    = '0;
                    if_id_pc_plus4_d = '0;
                    if_id_valid_d    = 1'b0;
                end else if (!stall) begin
                    pc_d             = next_pc;
                    if_id_instr_d    = instruction_in;
                    if_id_pc_plus4_d = pc_plus4;
                    if_id_valid_d    = 1'b1;
                    fetch_count_d    = fetch_count_q + DATA_WIDTH'(1);
                end
            end
            default: begin
                fault_d       = 1'b1;
                if_id_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q          <= RUN;
            pc_q             <= RESET_PC;
            if_id_instr_q    <= '0;
            if_id_pc_plus4_q <= '0;
            if_id_valid_q    <= 1'b0;
            fault_q          <= 1'b0;
            fetch_count_q    <= '0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            if_id_instr_q    <= if_id_instr_d;
            if_id_pc_plus4_q <= if_id_pc_plus4_d;
            if_id_valid_q    <= if_id_valid_d;
            fault_q          <= fault_d;
            fetch_count_q    <= fetch_count_d;
        end
    end

    assign pc_out         = pc_q;
    assign if_id_instr    = if_id_instr_q;
    assign if_id_pc_plus4 = if_id_pc_plus4_q;
    assign if_id_valid    = if_id_valid_q;
    assign fault          = fault_q;
    assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - table-driven scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  pc_src = 2'b00;
    logic [31:0] branch_target = '0;
    logic [25:0] jump_index = '0;
    logic [31:0] jr_address = '0;
    logic [31:0] instruction_in;
    logic [31:0] pc_out;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        fault;
    logic [31:0] fetch_count;

    // ROM model: word at address a is 0x10000000 + a
    assign instruction_in = 32'h1000_0000 + pc_out;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .pc_src         (pc_src),
        .branch_target  (branch_target),
        .jump_index     (jump_index),
        .jr_address     (jr_address),
        .instruction_in (instruction_in),
        .pc_out         (pc_out),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .fault          (fault),
        .fetch_count    (fetch_count)
    );

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        flush;
        logic [1:0]  pc_src;
        logic [31:0] bt;
        logic [25:0] ji;
        logic [31:0] jr;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_p4;
        logic        e_valid;
        logic        e_fault;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[28];
    vec_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic vec_t mk(input logic r, input logic s, input logic f, input logic [1:0] src,
                                input logic [31:0] bt, input logic [25:0] ji, input logic [31:0] jr,
                                input logic [31:0] epc, input logic [31:0] ein, input logic [31:0] ep4,
                                input logic ev, input logic ef, input logic [31:0] ec);
        vec_t v;
        v.rst_n = r; v.stall = s; v.flush = f; v.pc_src = src;
        v.bt = bt; v.ji = ji; v.jr = jr;
        v.e_pc = epc; v.e_instr = ein; v.e_p4 = ep4;
        v.e_valid = ev; v.e_fault = ef; v.e_cnt = ec;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL vec%0d %s: got %h expected %h", idx, name, act, exp);
        end
    endtask

    // Drive on the falling edge, record expectation, compare 1ns after the rising edge.
    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        reset = v.rst_n; stall = v.stall; flush = v.flush; pc_src = v.pc_src;
        branch_target = v.bt; jump_index = v.ji; jr_address = v.jr;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_vec++;
        check("pc_out", idx, pc_out, e.e_pc);
        check("if_id_instr", idx, if_id_instr, e.e_instr);
        check("if_id_pc_plus4", idx, if_id_pc_plus4, e.e_p4);
        check("if_id_valid", idx, {31'b0, if_id_valid}, {31'b0, e.e_valid});
        check("fault", idx, {31'b0, fault}, {31'b0, e.e_fault});
        check("fetch_count", idx, fetch_count, e.e_cnt);
    endtask

    initial begin
        logic [31:0] epc, ein, ep4, ecnt;
        //            rst s  f  src    bt            ji     jr         pc            instr         pc+4          v  f  cnt
        tbl[0]  = mk(0, 0, 0, 2'b00, 32'h0,        26'h0, 32'h0,  32'h0,        32'h0,        32'h0,        0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 2'b00, 32'h0,        26'h0, 32'h0,  32'h0,        32'h0,        32'h0,        0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 2'b00, 32'h0,        26'h0, 32'h0,  32'h4,        32'h10000000, 32'h4,        1, 0, 1);
        tbl[3]  = mk(1, 0, 0, 2'b00, 32'h0,        26'h0, 32'h0,  32'h8,        32'h10000004, 32'h8,        1, 0, 2);
        tbl[4]  = mk(1, 1, 0, 2'b00, 32'h0,        26'h0, 32'h0,  32'h8,        32'h10000004, 32'h8,        1, 0, 2);
        tbl[5]  = mk(1, 1, 0, 2'b00, 32'h0,        26'h0, 32'h0,  32'h8,        32'h10000004, 32'h8,        1, 0, 2);
        tbl[6]  = mk(1, 1, 0, 2'b00, 32'h0,        26'h0, 32'h0,  32'h8,        32'h10000004, 32'h8,        1, 0, 2);
        tbl[7]  = mk(1, 0, 0, 2'b00, 32'h0,        26'h0, 32'h0,  32'hC,        32'h10000008, 32'hC,        1, 0, 3);
        tbl[8]  = mk(1, 0, 0, 2'b00, 32'h0,        26'h0, 32'h0,  32'h10,       32'h1000000C, 32'h10,       1, 0, 4);
        tbl[9]  = mk(1, 0, 1, 2'b01, 32'h40,       26'h0, 32'h0,  32'h40,       32'h0,        32'h0,        0, 0, 4);
        tbl[10] = mk(1, 0, 0, 2'b00, 32'h0,        26'h0, 32'h0,  32'h44,       32'h10000040, 32'h44,       1, 0, 5);
        tbl[11] = mk(1, 1, 0, 2'b01, 32'h80,       26'h0, 32'h0,  32'h44,       32'h10000040, 32'h44,       1, 0, 5);
        tbl[12] = mk(1, 0, 1, 2'b01, 32'h10000004, 26'h0, 32'h0,  32'h10000004, 32'h0,        32'h0,        0, 0, 5);
        tbl[13] = mk(1, 0, 0, 2'b00, 32'h0,        26'h0, 32'h0,  32'h10000008, 32'h20000004, 32'h10000008, 1, 0, 6);
        tbl[14] = mk(1, 0, 1, 2'b10, 32'h0,        26'h10, 32'h0, 32'h10000040, 32'h0,        32'h0,        0, 0, 6);
        tbl[15] = mk(1, 0, 1, 2'b11, 32'h0,        26'h0, 32'h24, 32'h24,       32'h0,        32'h0,        0, 0, 6);
        tbl[16] = mk(1, 1, 1, 2'b00, 32'h0,        26'h0, 32'h0,  32'h28,       32'h0,        32'h0,        0, 0, 6);
        tbl[17] = mk(1, 0, 1, 2'b01, 32'hFFFFFFFC, 26'h0, 32'h0,  32'hFFFFFFFC, 32'h0,        32'h0,        0, 0, 6);
        tbl[18] = mk(1, 0, 0, 2'b00, 32'h0,        26'h0, 32'h0,  32'h0,        32'h0FFFFFFC, 32'h0,        1, 0, 7);
        tbl[19] = mk(1, 1, 0, 2'b11, 32'h0,        26'h0, 32'h26, 32'h0,        32'h0FFFFFFC, 32'h0,        1, 0, 7);
        tbl[20] = mk(1, 0, 1, 2'b11, 32'h0,        26'h0, 32'h26, 32'h0,        32'h0,        32'h0,        0, 1, 7);
        tbl[21] = mk(1, 0, 0, 2'b00, 32'h0,        26'h0, 32'h0,  32'h0,        32'h0,        32'h0,        0, 1, 7);
        tbl[22] = mk(1, 1, 1, 2'b01, 32'h100,      26'h0, 32'h0,  32'h0,        32'h0,        32'h0,        0, 1, 7);
        tbl[23] = mk(0, 0, 1, 2'b00, 32'h0,        26'h0, 32'h0,  32'h0,        32'h0,        32'h0,        0, 0, 0);
        tbl[24] = mk(1, 0, 0, 2'b00, 32'h0,        26'h0, 32'h0,  32'h4,        32'h10000000, 32'h4,        1, 0, 1);
        tbl[25] = mk(1, 0, 0, 2'b01, 32'h41,       26'h0, 32'h0,  32'h4,        32'h0,        32'h0,        0, 1, 1);
        tbl[26] = mk(0, 1, 0, 2'b00, 32'h0,        26'h0, 32'h0,  32'h0,        32'h0,        32'h0,        0, 0, 0);
        tbl[27] = mk(1, 0, 0, 2'b00, 32'h0,        26'h0, 32'h0,  32'h4,        32'h10000000, 32'h4,        1, 0, 1);

        for (int i = 0; i < 28; i++) apply(tbl[i], i);

        // Alternating stall/run from PC=4: each run edge advances PC and count, each stall holds all.
        epc = 32'h4; ein = 32'h10000000; ep4 = 32'h4; ecnt = 32'd1;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) begin
                ein  = 32'h10000000 + epc;
                ep4  = epc + 32'd4;
                epc  = epc + 32'd4;
                ecnt = ecnt + 32'd1;
            end
            apply(mk(1, (k % 2 == 1), 0, 2'b00, 32'h0, 26'h0, 32'h0,
                     epc, ein, ep4, 1, 0, ecnt), 100 + k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
